// File: rtl/multi_game_ctrl_if.sv
// Signal bundle between the multi-player game controller and the sensor/display/save side.
// The controller takes the slave modport; the environment driving it takes the master modport.
interface multi_game_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int TIME_W      = 7
);
  logic                           go;
  logic                           restart;
  logic                           sec_tick;
  logic [NUM_PLAYERS-1:0]         shot;
  logic                           done_save;
  logic [2:0]                     state;
  logic                           playing;
  logic                           ld_save;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [TIME_W-1:0]              time_left;
  logic [2:0]                     winner;
  logic                           tie;
  logic [NUM_PLAYERS-1:0]         score_evt;

  modport master (
    output go, restart, sec_tick, shot, done_save,
    input  state, playing, ld_save, scores, time_left, winner, tie, score_evt
  );

  modport slave (
    input  go, restart, sec_tick, shot, done_save,
    output state, playing, ld_save, scores, time_left, winner, tie, score_evt
  );
endinterface

// File: rtl/multi_game_ctrl.sv
// Timed multi-player hoop game controller: per-player edge detect, cooldown and saturating score.
// Optional macro MULTI_GAME_BONUS_EN: shots counted while time_left<=10 score 2 instead of 1.
module multi_game_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 8,
  parameter int TIME_W       = 7,
  parameter int GAME_SECS    = 60,
  parameter int COOLDOWN_CYC = 16
) (
  input  logic             clk,
  input  logic             resetn,
  multi_game_ctrl_if.slave bus
);
  localparam int CD_W = $clog2(COOLDOWN_CYC + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] PLAY = 3'd2;
  localparam logic [2:0] SAVE = 3'd3;

  logic [2:0]             state_q, state_d;
  logic [TIME_W-1:0]      time_q, time_d;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
  logic [CD_W-1:0]        cd_q    [NUM_PLAYERS];
  logic [CD_W-1:0]        cd_d    [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] shot_q, evt_q, evt_d, shot_edge;
  logic [2:0]             win_q, win_d;
  logic                   tie_q, tie_d;
  logic                   restart_take, clr, in_play;
  logic [1:0]             inc;
  logic [SCORE_W-1:0]     best;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0]         b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(b);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  assign restart_take = bus.restart && (state_q == ARM || state_q == PLAY || state_q == SAVE);
  assign clr          = (state_d == IDLE) || restart_take;
  assign in_play      = (state_q == PLAY);
  assign shot_edge    = bus.shot & ~shot_q;

`ifdef MULTI_GAME_BONUS_EN
  assign inc = (time_q <= TIME_W'(10)) ? 2'd2 : 2'd1;
`else
  assign inc = 2'd1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // restart outranks every other exit; unused codes fall back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.go) state_d = ARM;
      ARM:     if (bus.restart || !bus.go) state_d = PLAY;
      PLAY:    if (bus.restart) state_d = PLAY;
               else if (bus.sec_tick && time_q == TIME_W'(1)) state_d = SAVE;
      SAVE:    if (bus.restart) state_d = PLAY;
               else if (bus.done_save) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.state     = state_q;
    bus.playing   = (state_q == PLAY);
    bus.ld_save   = (state_q == SAVE);
    bus.time_left = time_q;
    bus.winner    = win_q;
    bus.tie       = tie_q;
    bus.score_evt = evt_q;
    bus.scores    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) bus.scores[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  always_comb begin
    time_d = time_q;
    if (clr) time_d = TIME_W'(GAME_SECS);
    else if (in_play && bus.sec_tick && time_q != '0) time_d = time_q - TIME_W'(1);
  end

  // Cooldown keeps running in every state so a player is never stuck mid-count.
  always_comb begin
    evt_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      cd_d[i]    = (cd_q[i] != '0) ? cd_q[i] - CD_W'(1) : cd_q[i];
      if (clr) begin
        score_d[i] = '0;
        cd_d[i]    = '0;
      end else if (in_play && shot_edge[i] && cd_q[i] == '0) begin
        evt_d[i]   = 1'b1;
        score_d[i] = sat_add(score_q[i], inc);
        cd_d[i]    = CD_W'(COOLDOWN_CYC);
      end
    end
  end

  // Strict > keeps the lowest index on ties.
  always_comb begin
    best  = score_q[0];
    win_d = '0;
    tie_d = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (score_q[i] > best) begin
        best  = score_q[i];
        win_d = 3'(i);
        tie_d = 1'b0;
      end else if (score_q[i] == best) begin
        tie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_q <= TIME_W'(GAME_SECS);
      shot_q <= '0;
      evt_q  <= '0;
      win_q  <= '0;
      tie_q  <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
        cd_q[i]    <= '0;
      end
    end else begin
      time_q <= time_d;
      shot_q <= bus.shot;
      evt_q  <= evt_d;
      win_q  <= win_d;
      tie_q  <= tie_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= score_d[i];
        cd_q[i]    <= cd_d[i];
      end
    end
  end
endmodule

// File: tb/tb_multi_game_ctrl.sv
// Bench for multi_game_ctrl: hand-computed vector table plus a per-cycle reference scoreboard.
module tb_multi_game_ctrl;
  localparam int NP   = 2;
  localparam int SW   = 3;
  localparam int TW   = 7;
  localparam int SECS = 60;
  localparam int COOL = 16;
  localparam int SMAX = (1 << SW) - 1;
`ifdef MULTI_GAME_BONUS_EN
  localparam int BON = 2;
`else
  localparam int BON = 1;
`endif

  logic clk, resetn;
  multi_game_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .TIME_W(TW)) bus();

  multi_game_ctrl #(.NUM_PLAYERS(NP), .SCORE_W(SW), .TIME_W(TW), .GAME_SECS(SECS),
                    .COOLDOWN_CYC(COOL)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int st; int s0; int s1; int tl; int win; int tie; int evt; } exp_t;
  typedef struct {
    bit go; bit rs; bit tk; bit [1:0] sh; bit dn; int reps;
    int st; int s0; int s1; int tl; int win; int tie;
  } vec_t;

  exp_t     sbq[$];
  vec_t     tbl[26];
  int       total = 0;
  int       bad   = 0;
  int       m_st, m_tl;
  int       m_sc[2];
  int       m_cd[2];
  bit [1:0] m_shd;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int s0_act();
    return int'(bus.scores[SW-1:0]);
  endfunction

  function automatic int s1_act();
    return int'(bus.scores[2*SW-1:SW]);
  endfunction

  task automatic model_reset();
    m_st = 0; m_tl = SECS; m_shd = '0;
    for (int i = 0; i < 2; i++) begin m_sc[i] = 0; m_cd[i] = 0; end
  endtask

  task automatic step(input bit g, input bit r, input bit t, input bit [1:0] sh, input bit d);
    exp_t e;
    int   ns, inc;
    bit   rt, clr;
    bus.go = g; bus.restart = r; bus.sec_tick = t; bus.shot = sh; bus.done_save = d;
    rt = r && (m_st == 1 || m_st == 2 || m_st == 3);
    case (m_st)
      0:       ns = g ? 1 : 0;
      1:       ns = (r || !g) ? 2 : 1;
      2:       ns = r ? 2 : ((t && m_tl == 1) ? 3 : 2);
      3:       ns = r ? 2 : (d ? 0 : 3);
      default: ns = 0;
    endcase
    clr = (ns == 0) || rt;
    if (m_sc[1] > m_sc[0]) begin e.win = 1; e.tie = 0; end
    else begin e.win = 0; e.tie = (m_sc[1] == m_sc[0]) ? 1 : 0; end
    e.evt = 0;
    inc = (m_tl <= 10) ? BON : 1;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_sc[i] = 0; m_cd[i] = 0;
      end else if (m_st == 2 && sh[i] && !m_shd[i] && m_cd[i] == 0) begin
        m_sc[i] = (m_sc[i] + inc > SMAX) ? SMAX : m_sc[i] + inc;
        m_cd[i] = COOL;
        e.evt   = e.evt | (1 << i);
      end else if (m_cd[i] > 0) begin
        m_cd[i] = m_cd[i] - 1;
      end
    end
    if (clr) m_tl = SECS;
    else if (m_st == 2 && t && m_tl > 0) m_tl = m_tl - 1;
    m_shd = sh;
    m_st  = ns;
    e.st = m_st; e.s0 = m_sc[0]; e.s1 = m_sc[1]; e.tl = m_tl;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: got no expected entry at %0t", $time);
    end else begin
      e = sbq.pop_front();
      chk("sb_state", int'(bus.state), e.st);
      chk("sb_playing", int'(bus.playing), (e.st == 2) ? 1 : 0);
      chk("sb_ld_save", int'(bus.ld_save), (e.st == 3) ? 1 : 0);
      chk("sb_score0", s0_act(), e.s0);
      chk("sb_score1", s1_act(), e.s1);
      chk("sb_time", int'(bus.time_left), e.tl);
      chk("sb_winner", int'(bus.winner), e.win);
      chk("sb_tie", int'(bus.tie), e.tie);
      chk("sb_evt", int'(bus.score_evt), e.evt);
    end
  endtask

  task automatic idle_cycles(input int n, input bit [1:0] sh);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, sh, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            go rs tk sh    dn reps  st s0      s1 tl  win tie
    tbl[0]  = '{0, 0, 0, 2'b00, 0, 2,    0, 0,      0, 60, 0,  1};
    tbl[1]  = '{1, 0, 0, 2'b00, 0, 3,    1, 0,      0, 60, 0,  1};
    tbl[2]  = '{0, 0, 0, 2'b00, 0, 1,    2, 0,      0, 60, -1, -1};
    tbl[3]  = '{0, 0, 0, 2'b01, 0, 1,    2, 1,      0, 60, -1, -1};
    tbl[4]  = '{0, 0, 0, 2'b00, 0, 4,    2, 1,      0, 60, -1, -1};
    tbl[5]  = '{0, 0, 0, 2'b01, 0, 1,    2, 1,      0, 60, -1, -1};
    tbl[6]  = '{0, 0, 0, 2'b00, 0, 14,   2, 1,      0, 60, -1, -1};
    tbl[7]  = '{0, 0, 0, 2'b01, 0, 1,    2, 2,      0, 60, -1, -1};
    tbl[8]  = '{0, 0, 0, 2'b00, 0, 20,   2, 2,      0, 60, 0,  0};
    tbl[9]  = '{0, 0, 0, 2'b11, 0, 1,    2, 3,      1, 60, -1, -1};
    tbl[10] = '{0, 0, 0, 2'b00, 0, 20,   2, 3,      1, 60, 0,  0};
    tbl[11] = '{0, 0, 0, 2'b10, 0, 1,    2, 3,      2, 60, -1, -1};
    tbl[12] = '{0, 0, 0, 2'b00, 0, 20,   2, 3,      2, 60, 0,  0};
    tbl[13] = '{0, 0, 0, 2'b10, 0, 1,    2, 3,      3, 60, -1, -1};
    tbl[14] = '{0, 0, 0, 2'b00, 0, 20,   2, 3,      3, 60, 0,  1};
    tbl[15] = '{0, 0, 0, 2'b10, 0, 1,    2, 3,      4, 60, -1, -1};
    tbl[16] = '{0, 0, 0, 2'b00, 0, 20,   2, 3,      4, 60, 1,  0};
    tbl[17] = '{0, 0, 1, 2'b00, 0, 59,   2, 3,      4, 1,  1,  0};
    tbl[18] = '{0, 0, 1, 2'b01, 0, 1,    3, 3+BON,  4, 0,  -1, -1};
    tbl[19] = '{0, 0, 0, 2'b00, 0, 1,    3, 3+BON,  4, 0,  -1, -1};
    tbl[20] = '{0, 0, 0, 2'b01, 0, 1,    3, 3+BON,  4, 0,  -1, -1};
    tbl[21] = '{0, 0, 0, 2'b00, 0, 3,    3, 3+BON,  4, 0,  0,  (BON == 1) ? 1 : 0};
    tbl[22] = '{0, 0, 0, 2'b00, 1, 1,    0, 0,      0, 60, -1, -1};
    tbl[23] = '{0, 0, 0, 2'b00, 0, 2,    0, 0,      0, 60, 0,  1};
    tbl[24] = '{1, 0, 0, 2'b00, 0, 1,    1, 0,      0, 60, -1, -1};
    tbl[25] = '{0, 0, 0, 2'b00, 0, 1,    2, 0,      0, 60, -1, -1};

    bus.go = 0; bus.restart = 0; bus.sec_tick = 0; bus.shot = '0; bus.done_save = 0;
    resetn = 1'b0;
    model_reset();
    #12;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_ld_save", int'(bus.ld_save), 0);
    chk("rst_scores", int'(bus.scores), 0);
    chk("rst_time", int'(bus.time_left), SECS);
    chk("rst_winner", int'(bus.winner), 0);
    chk("rst_tie", int'(bus.tie), 0);
    chk("rst_evt", int'(bus.score_evt), 0);
    #11 resetn = 1'b1;

    for (int v = 0; v < 26; v++) begin
      for (int k = 0; k < tbl[v].reps; k++)
        step(tbl[v].go, tbl[v].rs, tbl[v].tk, tbl[v].sh, tbl[v].dn);
      if (tbl[v].st  >= 0) chk($sformatf("tbl%0d_state", v), int'(bus.state), tbl[v].st);
      if (tbl[v].s0  >= 0) chk($sformatf("tbl%0d_score0", v), s0_act(), tbl[v].s0);
      if (tbl[v].s1  >= 0) chk($sformatf("tbl%0d_score1", v), s1_act(), tbl[v].s1);
      if (tbl[v].tl  >= 0) chk($sformatf("tbl%0d_time", v), int'(bus.time_left), tbl[v].tl);
      if (tbl[v].win >= 0) chk($sformatf("tbl%0d_winner", v), int'(bus.winner), tbl[v].win);
      if (tbl[v].tie >= 0) chk($sformatf("tbl%0d_tie", v), int'(bus.tie), tbl[v].tie);
    end

    // saturation: nine spaced shots on a 3-bit counter
    for (int n = 0; n < 9; n++) begin
      step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
      idle_cycles(19, 2'b00);
    end
    chk("sat_score0", s0_act(), SMAX);

    for (int k = 0; k < SECS; k++) step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("timeout_state", int'(bus.state), 3);
    chk("timeout_ld_save", int'(bus.ld_save), 1);
    chk("timeout_time", int'(bus.time_left), 0);

    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("restart_state", int'(bus.state), 2);
    chk("restart_ld_save", int'(bus.ld_save), 0);
    chk("restart_score0", s0_act(), 0);
    chk("restart_time", int'(bus.time_left), SECS);

    // late-game shots either side of the 10-second mark
    for (int k = 0; k < 49; k++) step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("late_time11", int'(bus.time_left), 11);
    step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    chk("late_shot11", s0_act(), 1);
    idle_cycles(19, 2'b00);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("late_time10", int'(bus.time_left), 10);
    step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    chk("late_shot10", s0_act(), 1 + BON);
    idle_cycles(2, 2'b00);

    // asynchronous reset between clock edges while playing
    #2 resetn = 1'b0;
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_playing", int'(bus.playing), 0);
    chk("arst_scores", int'(bus.scores), 0);
    chk("arst_time", int'(bus.time_left), SECS);
    chk("arst_winner", int'(bus.winner), 0);
    chk("arst_tie", int'(bus.tie), 0);
    #10 resetn = 1'b1;
    model_reset();
    sbq.delete();
    idle_cycles(2, 2'b00);
    chk("post_arst_state", int'(bus.state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_game_ctrl.md
Name: multi_game_ctrl

Overview:
Parametrised successor to the single-player arcade basketball game controller. Runs a timed game for NUM_PLAYERS hoops, with these per-player resources:
- a shot edge detector
- a shot cooldown (debounce) counter
- a saturating score counter

It produces the game state, the remaining time, the winner and the save handshake toward the high-score/save block. It sits between the hoop sensor inputs and the score display/save datapath.

Parameters:
NUM_PLAYERS, 2, number of hoops/players (1..8)
SCORE_W, 8, score counter width per player (binary)
TIME_W, 7, width of the seconds countdown
GAME_SECS, 60, game length in sec_tick pulses (must fit TIME_W)
COOLDOWN_CYC, 16, clk cycles a player's input is ignored after a counted shot (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  1  start button (level)
restart  in  1  one-cycle pulse: restart game from any non-IDLE state
sec_tick  in  1  one-cycle 1 Hz strobe from the clock divider
shot  in  NUM_PLAYERS  raw per-player hoop sensors (level, already synchronised)
done_save  in  1  save block finished
state  out  3  current state encoding
playing  out  1  high in PLAY
ld_save  out  1  save request, high throughout SAVE
scores  out  NUM_PLAYERS*SCORE_W  player i at bits [i*SCORE_W +: SCORE_W]
time_left  out  TIME_W  seconds remaining
winner  out  3  index of the highest score; lowest index on ties
tie  out  1  two or more players share the top score
score_evt  out  NUM_PLAYERS  one-cycle pulse per counted shot

Behaviour:
- Reset (async, resetn=0) forces all of the following. Exit is synchronous on the first clk edge after release.
  - state=IDLE; scores=0; time_left=GAME_SECS; cooldowns=0; shot history=0
  - outputs: ld_save=0, playing=0, score_evt=0, winner=0, tie=0
- State encoding: IDLE=0, ARM=1, PLAY=2, SAVE=3. Codes 4..7 are illegal and recover to IDLE next cycle.
- IDLE:
  - On entry, scores clear and time_left reloads to GAME_SECS.
  - go=1 -> ARM.
- ARM: go=0 -> PLAY, so the game starts on button release.
- PLAY: playing=1.
  - sec_tick with time_left>0 decrements time_left.
  - sec_tick with time_left==1 makes time_left 0 and moves to SAVE next cycle.
- Shot counting, per player i, PLAY only:
  - edge = shot[i] & ~shot_d[i], where shot_d is a 1-cycle registered copy.
  - A count happens when edge=1 and cooldown[i]==0. Then:
    - score[i] += 1, saturating at 2^SCORE_W-1
    - score_evt[i]=1 in the following cycle
    - cooldown[i] loads COOLDOWN_CYC
  - A nonzero cooldown decrements by 1 each cycle. Edges during cooldown are dropped.
  - Players are independent: simultaneous edges on several players all count in the same cycle.
  - A shot edge in the same cycle as the final sec_tick still counts.
- SAVE:
  - ld_save=1; scores, winner and tie are frozen.
  - done_save=1 -> IDLE, and ld_save drops next cycle.
  - Shots are ignored in SAVE.
- restart (ARM/PLAY/SAVE):
  - Next state is PLAY; scores clear, time_left reloads, cooldowns clear.
  - ld_save deasserts immediately on leaving SAVE.
  - restart in IDLE is ignored.
  - restart has priority over timeout, done_save and go.
- winner/tie are registered and updated every cycle from the current scores (1-cycle lag).
- The shot_d history updates in every state, so a sensor held high across a state change does not produce a false edge.

Optional Feature:
- Macro: MULTI_GAME_BONUS_EN.
- Defined: a counted shot taken while time_left<=10 adds 2, saturating.
- Undefined: every counted shot adds 1 and there is no bonus logic.

Test Plan:
- Startup: reset, then go=1 for 3 cycles, then go=0 -> state sequence IDLE, ARM, PLAY; time_left=60; scores=0.
- Cooldown: P0 edge at cycle t, a second edge at t+5 (COOLDOWN_CYC=16), a third edge at t+20 -> score0=2; exactly two score_evt[0] pulses.
- Simultaneous players: edges on P0 and P1 in the same cycle -> both scores +1; with 3 vs 3, tie=1 and winner=0; a further P1 shot -> tie=0, winner=1.
- Timeout/save: 60 sec_ticks -> SAVE with ld_save=1 and scores frozen against further shots; done_save pulse -> IDLE with ld_save=0; go again -> scores cleared.
- Saturation and restart: SCORE_W=3, 9 spaced shots -> score=7; restart pulse during SAVE -> PLAY with scores=0 and time_left=60.
- Async reset mid-PLAY: drop resetn between clk edges -> outputs clear immediately; bonus build: a shot at time_left=10 adds 2, at time_left=11 adds 1.
